// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-256 key-schedule constants and round-key store state type.
// Contents:
//   AES256_NR      - number of AES-256 rounds (14)
//   AES256_NUM_RK  - number of round keys, Nr+1 (15)
//   AES_RK_W       - round-key width in bits (128)
//   AES_RK_ADDR_W  - round-key index width (4)
//   rks_state_t    - round-key store FSM states
package aes_pkg;
    localparam int AES256_NR     = 14;
    localparam int AES256_NUM_RK = AES256_NR + 1;
    localparam int AES_RK_W      = 128;
    localparam int AES_RK_ADDR_W = 4;
    typedef enum logic [1:0] {IDLE, LOAD, READY, ZERO} rks_state_t;
endpackage

// File: rtl/aes256_round_key_store_if.sv
// aes256_round_key_store_if: load and read bus between keyexpansion/round datapath and the round-key store.
// Signals:
//   start      - begin a new key load (one-cycle pulse)
//   rk_valid   - round-key beat valid
//   rk_in      - round-key beat
//   rk_ready   - store accepts a beat this cycle
//   rd_en      - read request
//   rd_addr    - round-key index to read
//   rd_data    - registered read data
//   rd_valid   - read data valid pulse
//   rd_err     - illegal read pulse
//   keys_ready - all round keys loaded
//   busy       - load or zeroize in progress
//   zeroize    - wipe all stored keys (only with AES_RKS_ZEROIZE_EN)
// Modports: master drives requests/beats, slave is the store.
interface aes256_round_key_store_if
    import aes_pkg::*;
#(
    parameter int RK_W   = AES_RK_W,
    parameter int ADDR_W = AES_RK_ADDR_W
);
    logic              start;
    logic              rk_valid;
    logic [RK_W-1:0]   rk_in;
    logic              rk_ready;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [RK_W-1:0]   rd_data;
    logic              rd_valid;
    logic              rd_err;
    logic              keys_ready;
    logic              busy;
`ifdef AES_RKS_ZEROIZE_EN
    logic              zeroize;
    modport master (
        output start, rk_valid, rk_in, rd_en, rd_addr, zeroize,
        input  rk_ready, rd_data, rd_valid, rd_err, keys_ready, busy
    );
    modport slave (
        input  start, rk_valid, rk_in, rd_en, rd_addr, zeroize,
        output rk_ready, rd_data, rd_valid, rd_err, keys_ready, busy
    );
`else
    modport master (
        output start, rk_valid, rk_in, rd_en, rd_addr,
        input  rk_ready, rd_data, rd_valid, rd_err, keys_ready, busy
    );
    modport slave (
        input  start, rk_valid, rk_in, rd_en, rd_addr,
        output rk_ready, rd_data, rd_valid, rd_err, keys_ready, busy
    );
`endif
endinterface

// File: rtl/aes_rk_regfile.sv
// aes_rk_regfile: NUM_RK x RK_W round-key storage, one write port, one registered read port.
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-high reset (read register only; storage is not reset)
//   i_we     - write enable
//   i_waddr  - write slot
//   i_wdata  - write data
//   i_re     - read enable; o_rdata holds while low
//   i_rclr   - load zero into the read register instead of slot data
//   i_raddr  - read slot
//   o_rdata  - registered read data
module aes_rk_regfile
    import aes_pkg::*;
#(
    parameter int NUM_RK = AES256_NUM_RK,
    parameter int RK_W   = AES_RK_W,
    parameter int ADDR_W = AES_RK_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [RK_W-1:0]   i_wdata,
    input  logic              i_re,
    input  logic              i_rclr,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [RK_W-1:0]   o_rdata
);
    logic [RK_W-1:0] r_mem [NUM_RK];
    logic [RK_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    // Out-of-range or unloaded reads arrive with i_rclr set, so r_mem is never indexed past NUM_RK-1 on a kept value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rdata <= '0;
        else if (i_re) r_rdata <= i_rclr ? '0 : r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/aes256_round_key_store.sv
// aes256_round_key_store: captures the 15 AES-256 round keys streamed by keyexpansion and serves registered random-access reads.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - aes256_round_key_store_if.slave (load handshake, read port, status flags)
// Build option: define AES_RKS_ZEROIZE_EN to add bus.zeroize and the ZERO wipe state.
module aes256_round_key_store
    import aes_pkg::*;
#(
    parameter int NUM_RK = AES256_NUM_RK,
    parameter int RK_W   = AES_RK_W,
    parameter int ADDR_W = AES_RK_ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst,
    aes256_round_key_store_if.slave   bus
);
    // Counter must reach NUM_RK itself, which marks a complete set.
    localparam int CNT_W = $clog2(NUM_RK + 1);

    if ((2 ** ADDR_W) < NUM_RK) begin : g_bad_addr_w
        $error("ADDR_W too small for NUM_RK");
    end

    rks_state_t       r_state;
    logic [CNT_W-1:0] r_wr_cnt;
    logic             r_rk_ready;
    logic             r_keys_ready;
    logic             r_busy;
    logic             r_rd_valid;
    logic             r_rd_err;
    logic             w_zeroize;
    logic             w_start;
    logic             w_last;
    logic             w_beat;
    logic             w_zero_wr;
    logic             w_legal;
    logic [RK_W-1:0]  w_rd_data;

`ifdef AES_RKS_ZEROIZE_EN
    assign w_zeroize = bus.zeroize;
`else
    assign w_zeroize = 1'b0;
`endif

    // start is ignored while wiping; zeroize outranks both start and beats.
    assign w_start   = bus.start && r_state != ZERO && !w_zeroize;
    assign w_last    = r_wr_cnt == CNT_W'(NUM_RK - 1);
    assign w_beat    = r_rk_ready && bus.rk_valid && !w_start && !w_zeroize;
    assign w_zero_wr = r_state == ZERO;
    // A slot is readable only once committed, so a partial set is never exposed.
    assign w_legal   = (r_state == READY && int'(bus.rd_addr) < NUM_RK) ||
                       (r_state == LOAD && int'(bus.rd_addr) < int'(r_wr_cnt));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_wr_cnt     <= '0;
            r_rk_ready   <= 1'b0;
            r_keys_ready <= 1'b0;
            r_busy       <= 1'b0;
        end
`ifdef AES_RKS_ZEROIZE_EN
        else if (w_zeroize) begin
            r_state      <= ZERO;
            r_wr_cnt     <= '0;
            r_rk_ready   <= 1'b0;
            r_keys_ready <= 1'b0;
            r_busy       <= 1'b1;
        end
`endif
        else if (w_start) begin
            r_state      <= LOAD;
            r_wr_cnt     <= '0;
            r_rk_ready   <= 1'b1;
            r_keys_ready <= 1'b0;
            r_busy       <= 1'b1;
        end else begin
            case (r_state)
                LOAD: if (w_beat) begin
                    r_wr_cnt <= r_wr_cnt + 1'b1;
                    if (w_last) begin
                        r_state      <= READY;
                        r_rk_ready   <= 1'b0;
                        r_keys_ready <= 1'b1;
                        r_busy       <= 1'b0;
                    end
                end
`ifdef AES_RKS_ZEROIZE_EN
                ZERO: if (w_last) begin
                    r_state  <= IDLE;
                    r_wr_cnt <= '0;
                    r_busy   <= 1'b0;
                end else begin
                    r_wr_cnt <= r_wr_cnt + 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_err   <= 1'b0;
        end else begin
            r_rd_valid <= bus.rd_en && w_legal;
            r_rd_err   <= bus.rd_en && !w_legal;
        end
    end

    aes_rk_regfile #(
        .NUM_RK (NUM_RK),
        .RK_W   (RK_W),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_beat || w_zero_wr),
        .i_waddr (ADDR_W'(r_wr_cnt)),
        .i_wdata (w_zero_wr ? '0 : bus.rk_in),
        .i_re    (bus.rd_en),
        .i_rclr  (!w_legal),
        .i_raddr (bus.rd_addr),
        .o_rdata (w_rd_data)
    );

    assign bus.rk_ready   = r_rk_ready;
    assign bus.keys_ready = r_keys_ready;
    assign bus.busy       = r_busy;
    assign bus.rd_valid   = r_rd_valid;
    assign bus.rd_err     = r_rd_err;
    assign bus.rd_data    = w_rd_data;
endmodule

// File: doc/aes256_round_key_store.md
Name: aes256_round_key_store

Overview:
- Downstream consumer of keyexpansion.
- Captures the 15 AES-256 round keys (RK0..RK14, 128 bit each) as keyexpansion streams them out on out_key.
- Holds them in a register file and serves random-access, registered reads to the CTR-mode cipher round datapath.
- Provides load sequencing, status flags, and read-range checking.

Parameters:
- NUM_RK, 15, number of round keys stored (AES-256: Nr+1).
- RK_W, 128, round-key width in bits.
- ADDR_W, 4, round-key index width; must satisfy 2**ADDR_W >= NUM_RK.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a new key load and invalidates stored keys.
- rk_valid  in  1  round-key beat valid from keyexpansion.
- rk_in  in  RK_W  round-key beat (keyexpansion out_key).
- rk_ready  out  1  store accepts a beat this cycle.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  round-key index to read.
- rd_data  out  RK_W  read data, registered.
- rd_valid  out  1  rd_data valid (one-cycle pulse).
- rd_err  out  1  read targeted an unloaded or out-of-range index (one-cycle pulse).
- keys_ready  out  1  all NUM_RK keys loaded.
- busy  out  1  load (or zeroize) in progress.

Behaviour:
- Reset values: state=IDLE, wr_cnt=0, rk_ready=0, rd_data=0, rd_valid=0, rd_err=0, keys_ready=0, busy=0. Storage contents are not reset (regfile); they are unreadable until loaded.
- FSM states:
  - IDLE: no keys held. start -> LOAD.
  - LOAD: rk_ready=1, busy=1. A beat is accepted when rk_valid&&rk_ready; it writes slot[wr_cnt], then wr_cnt++. When the accepted beat has wr_cnt==NUM_RK-1: next state READY, keys_ready=1 the following cycle, wr_cnt holds NUM_RK.
  - READY: keys_ready=1, rk_ready=0. start -> LOAD.
- start in any state: next cycle state=LOAD, wr_cnt=0, keys_ready=0. Start has priority over a simultaneous beat; that beat is discarded.
- rk_valid while not in LOAD: ignored, no write.
- Reads, 1-cycle latency: rd_en at cycle N -> rd_valid or rd_err at N+1, never both.
  - Legal read: (state==READY && rd_addr<NUM_RK) || (state==LOAD && rd_addr<wr_cnt). Legal -> rd_data=slot[rd_addr], rd_valid=1.
  - Illegal read -> rd_data=0, rd_err=1.
  - rd_data holds its last value while rd_en=0.
- Same-cycle read and write to different slots are independent. A read of the slot being written that cycle is illegal by the rule above (addr==wr_cnt).
- Reads are serviced in every state, including during start.
- Async rst mid-load: immediately IDLE, keys_ready=0, wr_cnt=0. A partial key set is never exposed.

Optional Feature:
- Macro: AES_RKS_ZEROIZE_EN.
- When defined:
  - Adds input port zeroize (1 bit).
  - zeroize pulse in any state -> state ZERO, busy=1, keys_ready=0, rk_ready=0.
  - One slot is written with 0 per cycle, slot 0..NUM_RK-1, over 15 cycles; then IDLE.
  - start and beats are ignored during ZERO. Reads during ZERO return rd_err.
  - zeroize has priority over start in the same cycle.
- When undefined: no port, no ZERO state. Storage is never cleared.

Decomposition:
- Shared package aes_pkg: AES256_NR=14, AES256_NUM_RK=15, AES_RK_W=128, AES_RK_ADDR_W=4, and typedef enum rks_state_t {IDLE, LOAD, READY, ZERO}.
- One sub-module, aes_rk_regfile: NUM_RK x RK_W storage with one write port (we, waddr, wdata) and one registered read port. The FSM, legality check and flags stay in the top.

Test Plan:
- Reset: rst=1 -> all outputs 0. After release with no start: rd_en addr 0 -> rd_err=1, rd_data=0.
- Full load: start, then 15 back-to-back beats (RK0=RK1=128'h0123456789abcdef0123456789abcdef, RKi=128'h(i)... distinct pattern for i>=2) -> keys_ready=1 one cycle after beat 14. Read of each addr 0..14 returns its written value with rd_valid exactly one cycle later.
- Range/partial: after 5 accepted beats, read addr 4 -> rd_valid with RK4; read addr 5 -> rd_err. In READY, read addr 15 -> rd_err.
- Restart: start during LOAD after 7 beats, simultaneous with rk_valid -> that beat dropped, wr_cnt=0, keys_ready=0. New 15-beat load completes normally.
- Async reset mid-load (beat 9) -> outputs return to reset values immediately, without waiting for a clk edge. Following read addr 0 -> rd_err.
- AES_RKS_ZEROIZE_EN: zeroize in READY -> busy for 15 cycles, then IDLE. Start plus 15 zero-valued beats, then read addr 3 -> 128'h0. Zeroize together with start -> ZERO wins.
